// File: rtl/fu_issue_scheduler.sv
// Round-robin issue scheduler sharing one multi-cycle, non-pipelined functional unit
// among NUM_RS reservation stations, with a held CDB result request.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module fu_issue_scheduler #(
    parameter int NUM_RS     = 4,
    parameter int FU_LATENCY = 3,
    parameter int TAG_W      = `ROB_TAG_LEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_RS-1:0]         rs_req,
    input  logic [NUM_RS*TAG_W-1:0]   rs_rd_tag,
    input  logic                      flush,
    input  logic                      cdb_ack,
    output logic [NUM_RS-1:0]         rs_exec_stall,
    output logic                      issue_valid,
    output logic [$clog2(NUM_RS)-1:0] issue_sel,
    output logic                      fu_busy,
    output logic                      cdb_req,
    output logic [TAG_W-1:0]          cdb_tag
);

    localparam int SEL_W = $clog2(NUM_RS);
    localparam int CNT_W = (FU_LATENCY > 1) ? $clog2(FU_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [SEL_W-1:0]   rr_ptr_r;
    logic [TAG_W-1:0]   tag_q_r;

    logic               can_issue_s;
    logic               found_s;
    logic               grant_s;
    logic [SEL_W-1:0]   grant_idx_s;
    logic [SEL_W:0]     scan_idx_s;
    logic [SEL_W-1:0]   next_ptr_s;
    logic [NUM_RS-1:0]  stall_s;

    // A DONE unit frees up in the very cycle its result is accepted, giving zero-bubble reuse.
    assign can_issue_s = !flush && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && cdb_ack));

    // Round-robin scan: first requester at or after rr_ptr, wrapping modulo NUM_RS.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        scan_idx_s  = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            scan_idx_s = {1'b0, rr_ptr_r} + (SEL_W+1)'(k);
            if (scan_idx_s >= (SEL_W+1)'(NUM_RS)) begin
                scan_idx_s = scan_idx_s - (SEL_W+1)'(NUM_RS);
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (!found_s && rs_req[scan_idx_s[SEL_W-1:0]]) begin
                found_s     = 1'b1;
                grant_idx_s = scan_idx_s[SEL_W-1:0];
            end else begin
                found_s     = found_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    assign grant_s = can_issue_s && found_s;

    // Pointer advance past the granted station.
    always_comb begin
        if (grant_idx_s == SEL_W'(NUM_RS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + SEL_W'(1);
        end
    end

    // Only the granted station may release its entry.
    always_comb begin
        stall_s = {NUM_RS{1'b1}};
        if (grant_s) begin
            stall_s[grant_idx_s] = 1'b0;
        end else begin
            stall_s = {NUM_RS{1'b1}};
        end
    end

    // FSM next-state: flush dominates, then a grant, then normal progression.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
        end else if (grant_s) begin
            if (FU_LATENCY == 1) begin
                state_nxt_s = ST_DONE;
                cnt_nxt_s   = '0;
            end else begin
                state_nxt_s = ST_EXEC;
                cnt_nxt_s   = CNT_W'(FU_LATENCY - 1);
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_EXEC: begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_EXEC;
                    end
                end
                ST_DONE: begin
                    if (cdb_ack) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    // FSM state and occupancy counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Captured destination tag and round-robin pointer; both change only on a grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q_r  <= '0;
            rr_ptr_r <= '0;
        end else if (grant_s) begin
            tag_q_r  <= rs_rd_tag[grant_idx_s*TAG_W +: TAG_W];
            rr_ptr_r <= next_ptr_s;
        end else begin
            tag_q_r  <= tag_q_r;
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign rs_exec_stall = stall_s;
    assign issue_valid   = grant_s;
    assign issue_sel     = grant_s ? grant_idx_s : '0;
    assign fu_busy       = (state_r != ST_IDLE);
    assign cdb_req       = (state_r == ST_DONE);
    assign cdb_tag       = tag_q_r;

endmodule
